// File: rtl/running_block_multiplier_if.sv
// running_block_multiplier_if: operand load and product stream signals of the Comba multiplier
interface running_block_multiplier_if #(
  parameter int REGISTER_SIZE = 32
);
  logic                     valid_in;
  logic [REGISTER_SIZE-1:0] a_block_in;
  logic [REGISTER_SIZE-1:0] b_block_in;
  logic                     ready_out;
  logic                     valid_out;
  logic [REGISTER_SIZE-1:0] product_block_out;
  logic                     last_out;
  modport master (
    output valid_in, a_block_in, b_block_in,
    input  ready_out, valid_out, product_block_out, last_out
  );
  modport slave (
    input  valid_in, a_block_in, b_block_in,
    output ready_out, valid_out, product_block_out, last_out
  );
endinterface

// File: rtl/running_block_multiplier.sv
// running_block_multiplier: streaming product-scanning multiplier, one block product per cycle, LSB block first
module running_block_multiplier #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 64
) (
  input logic                       clk_in,
  input logic                       rst_n_in,
  running_block_multiplier_if.slave bus
);
  localparam int R  = REGISTER_SIZE;
  localparam int N  = NUM_BLOCKS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int KW = $clog2(2 * N);
  localparam int AW = 2 * R + $clog2(N) + 1;
  typedef enum logic [1:0] {LOADING, COMPUTING, FLUSH} state_t;
  state_t          r_state;
  logic [IW-1:0]   r_load;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   r_i;
  logic [AW-1:0]   r_acc;
  logic            r_valid;
  logic            r_last;
  logic [R-1:0]    r_prod;
  logic [R-1:0]    r_a_mem [N];
  logic [R-1:0]    r_b_mem [N];
  logic            w_accept;
  logic            w_col_end;
  logic            w_final;
  logic [KW-1:0]   w_hi;
  logic [KW-1:0]   w_k1;
  logic [KW-1:0]   w_lo_next;
  logic [IW-1:0]   w_j;
  logic [R-1:0]    w_a;
  logic [R-1:0]    w_b;
  logic [2*R-1:0]  w_prod;
  logic [AW-1:0]   w_acc_next;
  assign bus.ready_out         = r_state == LOADING;
  assign bus.valid_out         = r_valid;
  assign bus.last_out          = r_last;
  assign bus.product_block_out = r_prod;
  // Column bookkeeping and the single multiply-accumulate term for this cycle
  always_comb begin
    w_accept   = (r_state == LOADING) && bus.valid_in;
    w_hi       = r_k < KW'(N) ? r_k : KW'(N - 1);
    w_j        = IW'(r_k - r_i);
    w_a        = r_a_mem[IW'(r_i)];
    w_b        = r_b_mem[w_j];
    w_prod     = w_a * w_b;
    w_acc_next = r_acc + AW'(w_prod);
    w_col_end  = r_i == w_hi;
    w_final    = w_col_end && (r_k == KW'(2 * N - 2));
    w_k1       = r_k + KW'(1);
    w_lo_next  = w_k1 >= KW'(N) ? w_k1 - KW'(N - 1) : '0;
  end
  // Operand storage; contents are irrelevant after reset so it is not cleared
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_a_mem[r_load] <= bus.a_block_in;
      r_b_mem[r_load] <= bus.b_block_in;
    end
  end
  // Control FSM with registered output strobes; a column's low block leaves as its carry stays
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= LOADING;
      r_load  <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_prod  <= '0;
    end else begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      case (r_state)
        LOADING: begin
          if (w_accept) begin
            r_load  <= r_load == IW'(N - 1) ? '0 : r_load + IW'(1);
            r_state <= r_load == IW'(N - 1) ? COMPUTING : LOADING;
          end
        end
        COMPUTING: begin
          r_acc <= w_col_end ? w_acc_next >> R : w_acc_next;
          if (w_col_end) begin
            r_valid <= 1'b1;
            r_prod  <= w_acc_next[R-1:0];
            r_k     <= w_final ? '0 : w_k1;
            r_i     <= w_final ? '0 : w_lo_next;
            r_state <= w_final ? FLUSH : COMPUTING;
          end else begin
            r_i <= r_i + KW'(1);
          end
        end
        default: begin
          r_valid <= 1'b1;
          r_last  <= 1'b1;
          r_prod  <= r_acc[R-1:0];
          r_acc   <= '0;
          r_k     <= '0;
          r_i     <= '0;
          r_load  <= '0;
          r_state <= LOADING;
        end
      endcase
    end
  end
  // The final carry must fit in one block; anything above it means the datapath is broken
  always_ff @(posedge clk_in) begin
    if (rst_n_in && r_state == FLUSH)
      assert (r_acc[AW-1:R] == '0) else $error("running_block_multiplier: accumulator overflow at flush");
  end
endmodule

// File: tb/tb_running_block_multiplier.sv
// tb_running_block_multiplier: directed small-config tests plus randomized full-size regression
module tb_running_block_multiplier;
  logic clk = 1'b0;
  logic rst_n_s = 1'b0;
  logic rst_n_b = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [8:0]  q_s[$];
  logic [32:0] q_b[$];
  always #5 clk = ~clk;
  running_block_multiplier_if #(.REGISTER_SIZE(8))  s ();
  running_block_multiplier_if #(.REGISTER_SIZE(32)) b ();
  running_block_multiplier #(.REGISTER_SIZE(8), .NUM_BLOCKS(2)) u_small (
    .clk_in(clk), .rst_n_in(rst_n_s), .bus(s)
  );
  running_block_multiplier #(.REGISTER_SIZE(32), .NUM_BLOCKS(64)) u_big (
    .clk_in(clk), .rst_n_in(rst_n_b), .bus(b)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Scoreboard: every product pulse is matched against the oldest expected {last, block}
  always @(negedge clk) begin
    if (rst_n_s && s.valid_out) begin
      if (q_s.size() == 0) chk("s_extra_pulse", 64'(q_s.size()), 64'd1);
      else chk("s_block", {s.last_out, s.product_block_out}, q_s.pop_front());
    end
    if (rst_n_b && b.valid_out) begin
      if (q_b.size() == 0) chk("b_extra_pulse", 64'(q_b.size()), 64'd1);
      else chk("b_block", {b.last_out, b.product_block_out}, q_b.pop_front());
    end
  end
  task automatic load_s(input logic [15:0] a, input logic [15:0] bb, input int gap);
    logic [31:0] p;
    p = a * bb;
    for (int n = 0; n < 4; n++) q_s.push_back({n == 3, p[8*n +: 8]});
    for (int n = 0; n < 2; n++) begin
      s.valid_in   = 1'b1;
      s.a_block_in = a[8*n +: 8];
      s.b_block_in = bb[8*n +: 8];
      tick();
      s.valid_in = 1'b0;
      if (n == 0) repeat (gap) tick();
    end
  endtask
  task automatic wait_s();
    for (int c = 0; c < 100 && q_s.size() != 0; c++) tick();
    chk("s_drain", 64'(q_s.size()), 64'd0);
  endtask
  task automatic run_big(input logic [2047:0] a, input logic [2047:0] bb);
    logic [4095:0] p;
    p = {2048'b0, a} * {2048'b0, bb};
    for (int n = 0; n < 128; n++) q_b.push_back({n == 127, p[32*n +: 32]});
    for (int n = 0; n < 64; n++) begin
      b.valid_in   = 1'b1;
      b.a_block_in = a[32*n +: 32];
      b.b_block_in = bb[32*n +: 32];
      tick();
    end
    b.valid_in = 1'b0;
    for (int c = 0; c < 5000 && q_b.size() != 0; c++) tick();
    chk("b_drain", 64'(q_b.size()), 64'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [2047:0] ra;
    logic [2047:0] rb;
    logic [5:0]    vpat;
    s.valid_in = 1'b0; s.a_block_in = '0; s.b_block_in = '0;
    b.valid_in = 1'b0; b.a_block_in = '0; b.b_block_in = '0;
    repeat (3) tick();
    chk("rst_valid", s.valid_out, 1'b0);
    chk("rst_last", s.last_out, 1'b0);
    chk("rst_prod", s.product_block_out, 8'h00);
    chk("rst_ready", s.ready_out, 1'b1);
    chk("rst_big_ready", b.ready_out, 1'b1);
    chk("rst_big_prod", b.product_block_out, 32'h0);
    @(negedge clk);
    rst_n_s = 1'b1;
    rst_n_b = 1'b1;
    tick();
    // Max operands
    load_s(16'hFFFF, 16'hFFFF, 0);
    wait_s();
    // Pulse timing relative to first compute cycle
    load_s(16'h0102, 16'h0003, 0);
    vpat = 6'b111010;
    for (int r = 0; r < 6; r++) begin
      chk("t_valid", s.valid_out, vpat[r]);
      chk("t_last", s.last_out, r == 5);
      chk("t_ready", s.ready_out, r == 5);
      tick();
    end
    wait_s();
    // Gapped input, then stray valid_in during compute
    load_s(16'h0102, 16'h0003, 2);
    for (int r = 0; r < 3; r++) begin
      chk("g_ready", s.ready_out, 1'b0);
      s.valid_in = 1'b1; s.a_block_in = 8'hAA; s.b_block_in = 8'h55;
      tick();
    end
    s.valid_in = 1'b0;
    wait_s();
    // Reset in the middle of compute
    load_s(16'hFFFF, 16'hFFFF, 0);
    repeat (3) tick();
    chk("r_col1_valid", s.valid_out, 1'b1);
    @(negedge clk);
    #1 rst_n_s = 1'b0;
    #1;
    chk("r_valid", s.valid_out, 1'b0);
    chk("r_ready", s.ready_out, 1'b1);
    chk("r_prod", s.product_block_out, 8'h00);
    chk("r_pending", 64'(q_s.size()), 64'd2);
    q_s.delete();
    @(negedge clk);
    rst_n_s = 1'b1;
    tick();
    load_s(16'h0001, 16'h0001, 0);
    wait_s();
    // Back-to-back: next load starts in the last_out cycle
    load_s(16'h1234, 16'h5678, 0);
    for (int c = 0; c < 50 && s.last_out !== 1'b1; c++) tick();
    chk("bb_last", s.last_out, 1'b1);
    chk("bb_ready", s.ready_out, 1'b1);
    load_s(16'hABCD, 16'h00EF, 0);
    wait_s();
    // Full-size regression
    run_big({2048{1'b1}}, {2048{1'b1}});
    for (int t = 0; t < 9; t++) begin
      for (int w = 0; w < 64; w++) begin
        ra[32*w +: 32] = $urandom();
        rb[32*w +: 32] = $urandom();
      end
      run_big(ra, rb);
    end
    repeat (5) tick();
    chk("end_q_s", 64'(q_s.size()), 64'd0);
    chk("end_q_b", 64'(q_b.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
